// File: rtl/mem_port_arbiter_pkg.sv
// Shared definitions for mem_port_arbiter: FSM state, owner encodings and
// legal memory-latency bounds.
package mem_port_arbiter_pkg;

    localparam int unsigned MEM_LAT_MIN = 1;
    localparam int unsigned MEM_LAT_MAX = 4;
    localparam int unsigned CNT_W       = 3;

    typedef enum logic {
        ST_IDLE,
        ST_WAIT
    } arb_state_t;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_IF   = 2'd1,
        OWN_D    = 2'd2
    } owner_t;

endpackage

// File: rtl/mem_port_arbiter_lat_counter.sv
// mem_lat_counter: loadable down-counter that stops at zero; 'last' flags
// the final latency cycle (cnt == 1).
module mem_lat_counter
    import mem_port_arbiter_pkg::*;
#(
    parameter int unsigned W = CNT_W
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic [W-1:0] cnt,
    output logic         last
);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (cnt != '0) begin
            cnt <= cnt - W'(1);
        end
    end

    assign last = (cnt == W'(1));

endmodule

// File: rtl/mem_port_arbiter.sv
// Two-requester arbiter for a single-port synchronous RAM with fixed latency.
// Define ARB_ROUND_ROBIN_EN for round-robin conflicts; default is data-port priority.
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int unsigned ADDR_W  = 11,
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned MEM_LAT = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_gnt,
    output logic              if_rvalid,
    output logic [DATA_W-1:0] if_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_gnt,
    output logic              d_rvalid,
    output logic [DATA_W-1:0] d_rdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    if ((MEM_LAT < MEM_LAT_MIN) || (MEM_LAT > MEM_LAT_MAX)) begin : g_bad_lat
        $error("mem_port_arbiter: MEM_LAT=%0d outside %0d..%0d",
               MEM_LAT, MEM_LAT_MIN, MEM_LAT_MAX);
    end

    arb_state_t       state, state_nx;
    owner_t           owner, owner_nx;
    logic             op_we, op_we_nx;
    logic [CNT_W-1:0] cnt;
    logic             last;
    logic             ready;
    logic             if_win;
    logic             if_sel;
    logic             d_sel;
    logic             done;

    mem_lat_counter #(.W(CNT_W)) u_lat_cnt (
        .clk      (clk),
        .rst      (rst),
        .load     (if_sel | d_sel),
        .load_val (CNT_W'(MEM_LAT)),
        .cnt      (cnt),
        .last     (last)
    );

    assign ready = (state == ST_IDLE) || ((state == ST_WAIT) && last);
    assign done  = (state == ST_WAIT) && last;

`ifdef ARB_ROUND_ROBIN_EN
    owner_t last_gnt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            last_gnt <= OWN_D;
        end else if (if_sel || d_sel) begin
            last_gnt <= if_sel ? OWN_IF : OWN_D;
        end
    end

    assign if_win = if_req && (!d_req || (last_gnt == OWN_D));
`else
    // Data port wins conflicts: it carries the older instruction.
    assign if_win = if_req && !d_req;
`endif

    assign if_sel = rst && ready && if_win;
    assign d_sel  = rst && ready && d_req && !if_win;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= ST_IDLE;
            owner <= OWN_NONE;
            op_we <= 1'b0;
        end else begin
            state <= state_nx;
            owner <= owner_nx;
            op_we <= op_we_nx;
        end
    end

    always_comb begin
        state_nx  = state;
        owner_nx  = owner;
        op_we_nx  = op_we;
        if_gnt    = 1'b0;
        d_gnt     = 1'b0;
        mem_en    = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        if (if_sel) begin
            if_gnt   = 1'b1;
            mem_en   = 1'b1;
            mem_addr = if_addr;
            state_nx = ST_WAIT;
            owner_nx = OWN_IF;
            op_we_nx = 1'b0;
        end else if (d_sel) begin
            d_gnt     = 1'b1;
            mem_en    = 1'b1;
            mem_we    = d_we;
            mem_addr  = d_addr;
            mem_wdata = d_wdata;
            state_nx  = ST_WAIT;
            owner_nx  = OWN_D;
            op_we_nx  = d_we;
        end else if (done) begin
            state_nx = ST_IDLE;
            owner_nx = OWN_NONE;
            op_we_nx = 1'b0;
        end
    end

    // Completion is reported for the registered owner, independent of any new grant.
    assign if_rvalid = rst && done && (owner == OWN_IF);
    assign d_rvalid  = rst && done && (owner == OWN_D);
    assign if_rdata  = if_rvalid ? mem_rdata : '0;
    assign d_rdata   = (d_rvalid && !op_we) ? mem_rdata : '0;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed self-checking bench for mem_port_arbiter with MEM_LAT = 1, 2 and 3.
module tb_mem_port_arbiter;

`ifdef ARB_ROUND_ROBIN_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic clk;
    int   errors;
    int   checks;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Instance A: MEM_LAT=1 with a small read-only RAM model
    logic        a_rst, a_if_req, a_if_gnt, a_if_rvalid, a_d_req, a_d_we, a_d_gnt, a_d_rvalid;
    logic        a_mem_en, a_mem_we;
    logic [10:0] a_if_addr, a_d_addr, a_mem_addr;
    logic [31:0] a_if_rdata, a_d_wdata, a_d_rdata, a_mem_wdata, a_mem_rdata;
    logic [31:0] a_ram [0:15];

    // Instance B: MEM_LAT=2
    logic        b_rst, b_if_req, b_if_gnt, b_if_rvalid, b_d_req, b_d_we, b_d_gnt, b_d_rvalid;
    logic        b_mem_en, b_mem_we;
    logic [10:0] b_if_addr, b_d_addr, b_mem_addr;
    logic [31:0] b_if_rdata, b_d_wdata, b_d_rdata, b_mem_wdata, b_mem_rdata;

    // Instance C: MEM_LAT=3
    logic        c_rst, c_if_req, c_if_gnt, c_if_rvalid, c_d_req, c_d_we, c_d_gnt, c_d_rvalid;
    logic        c_mem_en, c_mem_we;
    logic [10:0] c_if_addr, c_d_addr, c_mem_addr;
    logic [31:0] c_if_rdata, c_d_wdata, c_d_rdata, c_mem_wdata, c_mem_rdata;

    mem_port_arbiter #(.ADDR_W(11), .DATA_W(32), .MEM_LAT(1)) dut_a (
        .clk(clk), .rst(a_rst),
        .if_req(a_if_req), .if_addr(a_if_addr), .if_gnt(a_if_gnt),
        .if_rvalid(a_if_rvalid), .if_rdata(a_if_rdata),
        .d_req(a_d_req), .d_we(a_d_we), .d_addr(a_d_addr), .d_wdata(a_d_wdata),
        .d_gnt(a_d_gnt), .d_rvalid(a_d_rvalid), .d_rdata(a_d_rdata),
        .mem_en(a_mem_en), .mem_we(a_mem_we), .mem_addr(a_mem_addr),
        .mem_wdata(a_mem_wdata), .mem_rdata(a_mem_rdata)
    );

    mem_port_arbiter #(.ADDR_W(11), .DATA_W(32), .MEM_LAT(2)) dut_b (
        .clk(clk), .rst(b_rst),
        .if_req(b_if_req), .if_addr(b_if_addr), .if_gnt(b_if_gnt),
        .if_rvalid(b_if_rvalid), .if_rdata(b_if_rdata),
        .d_req(b_d_req), .d_we(b_d_we), .d_addr(b_d_addr), .d_wdata(b_d_wdata),
        .d_gnt(b_d_gnt), .d_rvalid(b_d_rvalid), .d_rdata(b_d_rdata),
        .mem_en(b_mem_en), .mem_we(b_mem_we), .mem_addr(b_mem_addr),
        .mem_wdata(b_mem_wdata), .mem_rdata(b_mem_rdata)
    );

    mem_port_arbiter #(.ADDR_W(11), .DATA_W(32), .MEM_LAT(3)) dut_c (
        .clk(clk), .rst(c_rst),
        .if_req(c_if_req), .if_addr(c_if_addr), .if_gnt(c_if_gnt),
        .if_rvalid(c_if_rvalid), .if_rdata(c_if_rdata),
        .d_req(c_d_req), .d_we(c_d_we), .d_addr(c_d_addr), .d_wdata(c_d_wdata),
        .d_gnt(c_d_gnt), .d_rvalid(c_d_rvalid), .d_rdata(c_d_rdata),
        .mem_en(c_mem_en), .mem_we(c_mem_we), .mem_addr(c_mem_addr),
        .mem_wdata(c_mem_wdata), .mem_rdata(c_mem_rdata)
    );

    // Single-cycle synchronous read RAM behind instance A
    always @(posedge clk) begin
        if (a_mem_en) a_mem_rdata <= a_ram[a_mem_addr[3:0]];
    end

    task automatic chk1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic drive_edge;
        @(posedge clk);
        #1;
    endtask

    initial begin
        errors = 0;
        checks = 0;
        for (int i = 0; i < 16; i++) a_ram[i] = 32'h0;
        a_ram[4] = 32'h2002_0001;
        a_ram[6] = 32'h0000_0066;
        a_ram[7] = 32'h0000_0077;
        a_ram[8] = 32'h0000_0808;
        a_ram[0] = 32'h0000_00A0;
        a_ram[1] = 32'h0000_00A1;
        a_ram[2] = 32'h0000_00A2;
        a_mem_rdata = '0;

        a_rst = 1'b0; b_rst = 1'b0; c_rst = 1'b0;
        a_if_req = 1'b1; a_if_addr = 11'h004; a_d_req = 1'b1; a_d_we = 1'b0;
        a_d_addr = 11'h008; a_d_wdata = 32'h1111_1111;
        b_if_req = 1'b1; b_if_addr = 11'h001; b_d_req = 1'b1; b_d_we = 1'b1;
        b_d_addr = 11'h002; b_d_wdata = 32'h2222_2222; b_mem_rdata = 32'h0000_0055;
        c_if_req = 1'b1; c_if_addr = 11'h003; c_d_req = 1'b1; c_d_we = 1'b1;
        c_d_addr = 11'h004; c_d_wdata = 32'h3333_3333; c_mem_rdata = 32'hFFFF_FFFF;

        // Test 1: reset holds every output at zero even with both requests up
        @(negedge clk);
        chk1("rst_a_outs", |{a_if_gnt, a_if_rvalid, a_if_rdata, a_d_gnt, a_d_rvalid, a_d_rdata,
                             a_mem_en, a_mem_we, a_mem_addr, a_mem_wdata}, 1'b0);
        chk1("rst_b_outs", |{b_if_gnt, b_if_rvalid, b_if_rdata, b_d_gnt, b_d_rvalid, b_d_rdata,
                             b_mem_en, b_mem_we, b_mem_addr, b_mem_wdata}, 1'b0);
        chk1("rst_c_outs", |{c_if_gnt, c_if_rvalid, c_if_rdata, c_d_gnt, c_d_rvalid, c_d_rdata,
                             c_mem_en, c_mem_we, c_mem_addr, c_mem_wdata}, 1'b0);

        drive_edge();
        b_if_req = 1'b0; b_d_req = 1'b0; c_if_req = 1'b0; c_d_req = 1'b0;
        a_rst = 1'b1; b_rst = 1'b1; c_rst = 1'b1;
        @(negedge clk);
        chk1("rel_d_gnt", a_d_gnt, !RR);
        chk1("rel_if_gnt", a_if_gnt, RR);
        chk32("rel_mem_addr", {21'h0, a_mem_addr}, RR ? 32'h004 : 32'h008);

        drive_edge();
        a_if_req = 1'b0; a_d_req = 1'b0;
        @(negedge clk);
        chk1("rel_d_rvalid", a_d_rvalid, !RR);
        chk32("rel_d_rdata", a_d_rdata, RR ? 32'h0 : 32'h0000_0808);
        chk32("rel_if_rdata", a_if_rdata, RR ? 32'h2002_0001 : 32'h0);
        chk1("rel_idle_en", a_mem_en, 1'b0);

        // Test 2: single fetch, MEM_LAT=1
        drive_edge();
        a_if_req = 1'b1; a_if_addr = 11'h004;
        @(negedge clk);
        chk1("t2_if_gnt", a_if_gnt, 1'b1);
        chk1("t2_mem_en", a_mem_en, 1'b1);
        chk1("t2_mem_we", a_mem_we, 1'b0);
        chk32("t2_mem_addr", {21'h0, a_mem_addr}, 32'h004);
        chk32("t2_mem_wdata", a_mem_wdata, 32'h0);
        chk1("t2_c0_rvalid", a_if_rvalid, 1'b0);
        drive_edge();
        a_if_req = 1'b0;
        @(negedge clk);
        chk1("t2_if_rvalid", a_if_rvalid, 1'b1);
        chk32("t2_if_rdata", a_if_rdata, 32'h2002_0001);
        chk1("t2_c1_gnt", a_if_gnt, 1'b0);

        // Test 4: both requesters held for four grants
        drive_edge();
        a_if_req = 1'b1; a_if_addr = 11'h007; a_d_req = 1'b1; a_d_we = 1'b0; a_d_addr = 11'h006;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk1($sformatf("t4_d_gnt%0d", i), a_d_gnt, RR ? (i % 2 == 0) : 1'b1);
            chk1($sformatf("t4_if_gnt%0d", i), a_if_gnt, RR ? (i % 2 == 1) : 1'b0);
            if (i == 1) begin
                chk1("t4_d_rvalid1", a_d_rvalid, 1'b1);
                chk32("t4_d_rdata1", a_d_rdata, 32'h0000_0066);
            end
            if (i == 2 && RR) chk32("t4_if_rdata2", a_if_rdata, 32'h0000_0077);
            drive_edge();
        end
        a_if_req = 1'b0; a_d_req = 1'b0;
        drive_edge();

        // Test 6: back-to-back fetches at 0,1,2
        for (int k = 0; k < 4; k++) begin
            a_if_req = (k < 3);
            a_if_addr = 11'(k);
            @(negedge clk);
            if (k < 3) begin
                chk1($sformatf("t6_if_gnt%0d", k), a_if_gnt, 1'b1);
                chk32($sformatf("t6_mem_addr%0d", k), {21'h0, a_mem_addr}, 32'(k));
            end
            if (k > 0) begin
                chk1($sformatf("t6_if_rvalid%0d", k), a_if_rvalid, 1'b1);
                chk32($sformatf("t6_if_rdata%0d", k), a_if_rdata, 32'h0000_00A0 + 32'(k - 1));
            end
            drive_edge();
        end
        a_if_req = 1'b0;

        // Test 3: MEM_LAT=3 store blocks the fetch port for two cycles
        c_d_req = 1'b1; c_d_we = 1'b1; c_d_addr = 11'h010; c_d_wdata = 32'hDEAD_BEEF;
        c_if_req = 1'b0; c_if_addr = 11'h020;
        @(negedge clk);
        chk1("t3_d_gnt", c_d_gnt, 1'b1);
        chk1("t3_mem_we", c_mem_we, 1'b1);
        chk32("t3_mem_addr", {21'h0, c_mem_addr}, 32'h010);
        chk32("t3_mem_wdata", c_mem_wdata, 32'hDEAD_BEEF);
        drive_edge();
        c_d_req = 1'b0; c_if_req = 1'b1;
        for (int j = 1; j < 3; j++) begin
            @(negedge clk);
            chk1($sformatf("t3_if_gnt_c%0d", j), c_if_gnt, 1'b0);
            chk1($sformatf("t3_mem_en_c%0d", j), c_mem_en, 1'b0);
            chk1($sformatf("t3_d_rvalid_c%0d", j), c_d_rvalid, 1'b0);
            drive_edge();
        end
        @(negedge clk);
        chk1("t3_d_rvalid_c3", c_d_rvalid, 1'b1);
        chk32("t3_d_rdata_c3", c_d_rdata, 32'h0);
        chk1("t3_if_gnt_c3", c_if_gnt, 1'b1);
        chk32("t3_mem_addr_c3", {21'h0, c_mem_addr}, 32'h020);
        chk1("t3_mem_we_c3", c_mem_we, 1'b0);
        drive_edge();
        c_if_req = 1'b0;
        drive_edge();
        drive_edge();
        @(negedge clk);
        chk1("t3_if_rvalid_c6", c_if_rvalid, 1'b1);
        chk32("t3_if_rdata_c6", c_if_rdata, 32'hFFFF_FFFF);

        // Test 5: MEM_LAT=2 load aborted by reset at c1
        drive_edge();
        b_d_req = 1'b1; b_d_we = 1'b0; b_d_addr = 11'h005;
        @(negedge clk);
        chk1("t5_d_gnt", b_d_gnt, 1'b1);
        chk1("t5_mem_we", b_mem_we, 1'b0);
        drive_edge();
        b_d_req = 1'b0; b_rst = 1'b0;
        @(negedge clk);
        chk1("t5_rst_rvalid", b_d_rvalid, 1'b0);
        chk1("t5_rst_en", b_mem_en, 1'b0);
        drive_edge();
        @(negedge clk);
        chk1("t5_rst_rvalid2", b_d_rvalid, 1'b0);
        drive_edge();
        b_rst = 1'b1;
        @(negedge clk);
        chk1("t5_rel_rvalid", b_d_rvalid, 1'b0);
        drive_edge();
        b_d_req = 1'b1; b_d_addr = 11'h006;
        @(negedge clk);
        chk1("t5_new_gnt", b_d_gnt, 1'b1);
        chk32("t5_new_addr", {21'h0, b_mem_addr}, 32'h006);
        drive_edge();
        b_d_req = 1'b0;
        @(negedge clk);
        chk1("t5_new_c1_rvalid", b_d_rvalid, 1'b0);
        drive_edge();
        @(negedge clk);
        chk1("t5_new_c2_rvalid", b_d_rvalid, 1'b1);
        chk32("t5_new_c2_rdata", b_d_rdata, 32'h0000_0055);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
